// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 4;
   localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract.
module div_restore_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic             q_msb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] r_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] t;

   assign t       = {r_i, q_msb_i};
   assign q_bit_o = (t >= {1'b0, divisor_i});
   // After a successful subtract the result is below divisor, so the
   // low WIDTH bits of the difference are exact.
   assign r_o     = q_bit_o ? (t[WIDTH-1:0] - divisor_i)
                            : t[WIDTH-1:0];

endmodule

// File: rtl/seq_unsigned_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_unsigned_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_w(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             zf_q, zf_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] step_r;
   logic             step_b;

   div_restore_step #(.WIDTH(WIDTH)) u_step (
      .r_i       (r_q),
      .q_msb_i   (sh_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .r_o       (step_r),
      .q_bit_o   (step_b)
   );

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      sh_d    = sh_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      zf_d    = zf_q;
      dz_d    = dz_q;
      unique case (state_q)
         S_IDLE, S_FIN: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_CALC;
               r_d     = '0;
               sh_d    = dividend;
               dvs_d   = divisor;
               zf_d    = (divisor == '0);
               // A zero divisor takes one CALC cycle so done lands on E1.
               cnt_d   = (divisor == '0) ? CW'(1) : CW'(WIDTH);
            end
         end
         S_CALC: begin
            r_d   = step_r;
            sh_d  = {sh_q[WIDTH-2:0], step_b};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIN;
               quot_d  = zf_q ? '1 : {sh_q[WIDTH-2:0], step_b};
               rem_d   = zf_q ? sh_q : step_r;
               dz_d    = zf_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         r_q     <= '0;
         sh_q    <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         zf_q    <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         sh_q    <= sh_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         zf_q    <= zf_d;
         dz_q    <= dz_d;
      end
   end

   assign busy        = (state_q == S_CALC);
   assign done        = (state_q == S_FIN);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Self-checking bench for seq_unsigned_divider against a/b, a%b.
module tb_seq_unsigned_divider;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int n_chk = 0;
   int n_err = 0;
   int prev_q = 0;
   int prev_r = 0;

   seq_unsigned_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int m_q(input int a, input int b);
      return (b == 0) ? MAXV : a / b;
   endfunction

   function automatic int m_r(input int a, input int b);
      return (b == 0) ? a : a % b;
   endfunction

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < W + 4) begin
         tick();
         cyc++;
      end
   endtask

   task automatic do_div(input int a, input int b, input string tag);
      int cyc;
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_hold"}, quotient, prev_q);
      wait_done(cyc);
      check({tag, "_lat"}, cyc, (b == 0) ? 1 : W);
      check({tag, "_q"}, quotient, m_q(a, b));
      check({tag, "_r"}, remainder, m_r(a, b));
      check({tag, "_dz"}, div_by_zero, (b == 0) ? 1 : 0);
      check({tag, "_nbusy"}, busy, 0);
      prev_q = m_q(a, b);
      prev_r = m_r(a, b);
      tick();
      check({tag, "_pulse"}, done, 0);
   endtask

   initial begin
      int cyc;
      int seen;
      int correct;
      int a, b;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dz", div_by_zero, 0);
      rst = 1'b0;
      tick();

      do_div(13, 4, "d13_4");
      do_div(15, 1, "d15_1");
      do_div(15, 15, "d15_15");
      do_div(0, 7, "d0_7");
      do_div(7, 9, "d7_9");
      do_div(9, 0, "d9_0");
      do_div(8, 3, "d8_3");

      // start while busy must be dropped
      dividend = 13; divisor = 4; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      dividend = 2; divisor = 1; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(cyc);
      check("ign_lat", cyc, W - 2);
      check("ign_q", quotient, 3);
      check("ign_r", remainder, 1);
      seen = 0;
      for (int i = 0; i < 2 * W; i++) begin
         tick();
         if (done) seen++;
      end
      check("ign_nodone", seen, 0);
      prev_q = 3;
      prev_r = 1;

      // asynchronous reset mid-operation
      dividend = 14; divisor = 3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_q", quotient, 0);
      check("arst_r", remainder, 0);
      check("arst_dz", div_by_zero, 0);
      tick();
      rst = 1'b0;
      prev_q = 0;
      prev_r = 0;
      tick();
      do_div(14, 3, "d14_3");

      // exhaustive, back-to-back with start held high
      correct  = 0;
      dividend = 0;
      divisor  = 0;
      start    = 1'b1;
      tick();
      for (int i = 0; i < 256; i++) begin
         a = i / 16;
         b = i % 16;
         wait_done(cyc);
         check("exh_lat", cyc, (b == 0) ? 1 : W);
         check("exh_q", quotient, m_q(a, b));
         check("exh_r", remainder, m_r(a, b));
         check("exh_dz", div_by_zero, (b == 0) ? 1 : 0);
         if (b != 0) begin
            if (int'(quotient) * b + int'(remainder) == a &&
                int'(remainder) < b && !div_by_zero)
               correct++;
         end else if (quotient == W'(MAXV) &&
                      int'(remainder) == a && div_by_zero) begin
            correct++;
         end
         if (i < 255) begin
            dividend = W'((i + 1) / 16);
            divisor  = W'((i + 1) % 16);
         end else begin
            start = 1'b0;
         end
         tick();
         check("exh_pulse", done, 0);
         if (i < 255) check("exh_acc", busy, 1);
      end
      $display("correct total: %0d / 256", correct);
      check("exh_total", correct, 256);
      prev_q = m_q(15, 15);
      prev_r = m_r(15, 15);

      for (int k = 0; k < 40; k++) begin
         a = $urandom_range(0, MAXV);
         b = $urandom_range(0, MAXV);
         do_div(a, b, "rnd");
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule
